// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the multiplexed-bus RTC reader: sequencer
// and bus-phase enums, register map, and the packed bus-control word.
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        READ,
        DONE,
        WAIT
    } seq_state_t;

    typedef enum logic [1:0] {
        ADR,
        GAP1,
        DAT,
        GAP2
    } bus_phase_t;

    localparam int NUM_REGS = 6;

    // Time/date registers in snapshot order: sec, min, hour, day, mon, year
    localparam logic [7:0] REG_ADDR [NUM_REGS] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
    localparam logic [7:0] ADDR_LATCH = 8'hF0;

    typedef struct packed {
        logic cs_n;
        logic ad_sel;
        logic rd_n;
        logic wr_n;
    } bus_ctrl_t;

    localparam bus_ctrl_t BUS_IDLE   = '{cs_n: 1'b1, ad_sel: 1'b1, rd_n: 1'b1, wr_n: 1'b1};
    localparam bus_ctrl_t BUS_ADR_WR = '{cs_n: 1'b0, ad_sel: 1'b0, rd_n: 1'b1, wr_n: 1'b0};
    localparam bus_ctrl_t BUS_DAT_WR = '{cs_n: 1'b0, ad_sel: 1'b1, rd_n: 1'b1, wr_n: 1'b0};
    localparam bus_ctrl_t BUS_DAT_RD = '{cs_n: 1'b0, ad_sel: 1'b1, rd_n: 1'b0, wr_n: 1'b1};

endpackage

// File: rtl/rtc_bus_cycle.sv
// Runs one RTC bus transaction (ADR, GAP1, DAT, GAP2 of PHASE_CYC cycles each).
// A start accepted on the last GAP2 cycle chains the next transaction with no idle gap.
module rtc_bus_cycle
    import rtc_bus_pkg::*;
#(
    parameter int unsigned PHASE_CYC = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic [7:0] ad_in,
    output bus_ctrl_t  bus,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       done,
    output logic [7:0] rdata,
    output logic       rdata_vld
);

    localparam int unsigned CW = $clog2(PHASE_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(PHASE_CYC - 1);

    logic          active, nxt_active;
    bus_phase_t    phase, nxt_phase;
    logic [CW-1:0] cnt, nxt_cnt;
    logic          cur_rw, nxt_rw;
    logic [7:0]    cur_addr, nxt_addr;
    logic [7:0]    cur_wdata, nxt_wdata;
    logic          last, accept, sample;

    always_comb begin
        last       = (cnt == CNT_LAST);
        accept     = start && (!active || (phase == GAP2 && last));
        sample     = active && (phase == DAT) && last && cur_rw;
        nxt_active = active;
        nxt_phase  = phase;
        nxt_cnt    = cnt;
        nxt_rw     = cur_rw;
        nxt_addr   = cur_addr;
        nxt_wdata  = cur_wdata;
        if (active) begin
            nxt_cnt = last ? '0 : cnt + 1'b1;
        end
        if (accept) begin
            nxt_active = 1'b1;
            nxt_phase  = ADR;
            nxt_cnt    = '0;
            nxt_rw     = rw;
            nxt_addr   = addr;
            nxt_wdata  = wdata;
        end else if (active && last) begin
            unique case (phase)
                ADR:     nxt_phase = GAP1;
                GAP1:    nxt_phase = DAT;
                DAT:     nxt_phase = GAP2;
                GAP2:    nxt_active = 1'b0;
                default: nxt_active = 1'b0;
            endcase
        end
    end

    // Bus outputs are decoded from the next phase so they change on the same
    // edge as the phase register.
    always_ff @(posedge clk) begin
        if (reset) begin
            active    <= 1'b0;
            phase     <= ADR;
            cnt       <= '0;
            cur_rw    <= 1'b0;
            cur_addr  <= '0;
            cur_wdata <= '0;
            bus       <= BUS_IDLE;
            ad_out    <= '0;
            ad_oe     <= 1'b0;
            done      <= 1'b0;
            rdata     <= '0;
            rdata_vld <= 1'b0;
        end else begin
            active    <= nxt_active;
            phase     <= nxt_phase;
            cnt       <= nxt_cnt;
            cur_rw    <= nxt_rw;
            cur_addr  <= nxt_addr;
            cur_wdata <= nxt_wdata;
            done      <= nxt_active && (nxt_phase == GAP2) && (nxt_cnt == CNT_LAST);
            rdata_vld <= sample;
            if (sample) begin
                rdata <= ad_in;
            end
            bus   <= BUS_IDLE;
            ad_oe <= 1'b0;
            if (nxt_active) begin
                unique case (nxt_phase)
                    ADR: begin
                        bus    <= BUS_ADR_WR;
                        ad_oe  <= 1'b1;
                        ad_out <= nxt_addr;
                    end
                    GAP1: ad_oe <= 1'b1;
                    DAT: begin
                        if (nxt_rw) begin
                            bus <= BUS_DAT_RD;
                        end else begin
                            bus    <= BUS_DAT_WR;
                            ad_oe  <= 1'b1;
                            ad_out <= nxt_wdata;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/rtc_time_reader.sv
// Periodic RTC time/date reader: latch command, six BCD register reads,
// then an atomic snapshot update followed by a refresh wait.
module rtc_time_reader
    import rtc_bus_pkg::*;
#(
    parameter int unsigned PHASE_CYC   = 4,
    parameter int unsigned REFRESH_CYC = 100000,
    parameter logic [7:0]  LATCH_ADDR  = ADDR_LATCH,
    parameter logic [7:0]  BASE_ADDR   = REG_ADDR[0]
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init_done,
    input  logic       hold,
    output logic       cs_n,
    output logic       ad_sel,
    output logic       rd_n,
    output logic       wr_n,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in,
    output logic [7:0] sec,
    output logic [7:0] min,
    output logic [7:0] hour,
    output logic [7:0] day,
    output logic [7:0] mon,
    output logic [7:0] year,
    output logic       data_valid,
    output logic       busy
);

    localparam int unsigned RW = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
    // DONE and IDLE each take one cycle of the refresh gap, so WAIT covers the rest.
    localparam int unsigned WAIT_LAST = (REFRESH_CYC > 3) ? REFRESH_CYC - 3 : 0;
    localparam logic [RW-1:0] WAIT_TC = RW'(WAIT_LAST);

    seq_state_t state, nxt_state;
    logic [2:0]    idx;
    logic [RW-1:0] rcnt;
    logic [7:0]    shadow [NUM_REGS];
    logic          hold_seen;
    logic          last_read;
    logic          start, rw;
    logic [7:0]    addr;
    bus_ctrl_t     bus;
    logic          bus_done;
    logic [7:0]    rdata;
    logic          rdata_vld;

    rtc_bus_cycle #(
        .PHASE_CYC(PHASE_CYC)
    ) u_bus (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rw       (rw),
        .addr     (addr),
        .wdata    (8'h00),
        .ad_in    (ad_in),
        .bus      (bus),
        .ad_out   (ad_out),
        .ad_oe    (ad_oe),
        .done     (bus_done),
        .rdata    (rdata),
        .rdata_vld(rdata_vld)
    );

    assign cs_n   = bus.cs_n;
    assign ad_sel = bus.ad_sel;
    assign rd_n   = bus.rd_n;
    assign wr_n   = bus.wr_n;

    always_comb begin
        nxt_state = state;
        start     = 1'b0;
        rw        = 1'b1;
        addr      = LATCH_ADDR;
        last_read = (idx == 3'(NUM_REGS - 1));
        unique case (state)
            IDLE: begin
                if (init_done && !hold) begin
                    nxt_state = LATCH;
                    start     = 1'b1;
                    rw        = 1'b0;
                end
            end
            LATCH: begin
                if (bus_done) begin
                    nxt_state = READ;
                    start     = 1'b1;
                    addr      = BASE_ADDR;
                end
            end
            READ: begin
                if (bus_done) begin
                    if (last_read) begin
                        nxt_state = DONE;
                    end else begin
                        start = 1'b1;
                        addr  = BASE_ADDR + {5'd0, idx} + 8'd1;
                    end
                end
            end
            DONE: nxt_state = WAIT;
            WAIT: begin
                if (rcnt == WAIT_TC) begin
                    nxt_state = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            rcnt       <= '0;
            hold_seen  <= 1'b0;
            busy       <= 1'b0;
            data_valid <= 1'b0;
            sec        <= '0;
            min        <= '0;
            hour       <= '0;
            day        <= '0;
            mon        <= '0;
            year       <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            state      <= nxt_state;
            busy       <= (nxt_state == LATCH) || (nxt_state == READ);
            data_valid <= 1'b0;

            // Any hold seen during the burst discards its results at DONE.
            if (state == IDLE && nxt_state == LATCH) begin
                hold_seen <= 1'b0;
            end else if ((state == LATCH || state == READ) && hold) begin
                hold_seen <= 1'b1;
            end

            if (state == LATCH && bus_done) begin
                idx <= '0;
            end else if (state == READ && bus_done && !last_read) begin
                idx <= idx + 3'd1;
            end

            if (state == READ && rdata_vld) begin
                shadow[idx] <= rdata;
            end

            if (state == READ && nxt_state == DONE && !hold_seen && !hold) begin
                sec        <= shadow[0];
                min        <= shadow[1];
                hour       <= shadow[2];
                day        <= shadow[3];
                mon        <= shadow[4];
                year       <= shadow[5];
                data_valid <= 1'b1;
            end

            if (state == DONE) begin
                rcnt <= '0;
            end else if (state == WAIT && rcnt != WAIT_TC) begin
                rcnt <= rcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rtc_time_reader.sv
// Self-checking bench for rtc_time_reader: an RTC bus model answers reads, and a
// scoreboard compares every bus transaction and every snapshot against queued expectations.
module tb_rtc_time_reader;

    typedef logic [32:0] trans_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       init_done;
    logic       hold;
    logic       cs_n, ad_sel, rd_n, wr_n, ad_oe;
    logic [7:0] ad_out;
    logic [7:0] ad_in = 8'hEE;
    logic [7:0] sec, min, hour, day, mon, year;
    logic       data_valid, busy;

    int num_checks = 0;
    int num_errors = 0;

    logic [7:0]  rtc_mem [256];
    trans_t      exp_q [$];
    logic [47:0] snap_q [$];
    logic [47:0] cur_snap = '0;

    int  cyc = 0;
    int  busy_rises = 0, busy_rise_cyc = 0;
    int  dv_count = 0, dv_cyc = 0;
    int  trans_done = 0;
    int  proto_err = 0, stable_err = 0;
    bit  prev_busy = 1'b0;
    bit  in_trans = 1'b0;
    bit  cur_rw = 1'b0;
    logic [7:0] cur_addr = '0, cur_data = '0;
    int  adr_cyc = 0, dat_cyc = 0;

    rtc_time_reader #(
        .PHASE_CYC  (4),
        .REFRESH_CYC(200)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .init_done (init_done),
        .hold      (hold),
        .cs_n      (cs_n),
        .ad_sel    (ad_sel),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .ad_out    (ad_out),
        .ad_oe     (ad_oe),
        .ad_in     (ad_in),
        .sec       (sec),
        .min       (min),
        .hour      (hour),
        .day       (day),
        .mon       (mon),
        .year      (year),
        .data_valid(data_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [47:0] vals, input bit commit);
        exp_q.push_back({1'b0, 8'hF0, 8'h00, 8'd4, 8'd4});
        for (int i = 0; i < 6; i++) begin
            rtc_mem[8'(8'h21 + i)] = vals[47 - 8*i -: 8];
            exp_q.push_back({1'b1, 8'(8'h21 + i), vals[47 - 8*i -: 8], 8'd4, 8'd4});
        end
        if (commit) begin
            snap_q.push_back(vals);
        end
    endtask

    task automatic waitDv(input int target, input int limit, input string tag);
        for (int i = 0; i < limit && dv_count < target; i++) @(negedge clk);
        checkOutput(tag, dv_count, target);
    endtask

    task automatic waitBusy(input int target, input int limit, input string tag);
        for (int i = 0; i < limit && busy_rises < target; i++) @(negedge clk);
        checkOutput(tag, busy_rises, target);
    endtask

    task automatic waitTrans(input int target, input int limit, input string tag);
        for (int i = 0; i < limit && trans_done < target; i++) @(negedge clk);
        checkOutput(tag, trans_done, target);
    endtask

    // Bus monitor, RTC read model and scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            in_trans  = 1'b0;
            prev_busy = 1'b0;
            cur_snap  = '0;
            ad_in     = 8'hEE;
            exp_q.delete();
            snap_q.delete();
        end else begin
            if (busy && !prev_busy) begin
                busy_rises++;
                busy_rise_cyc = cyc;
            end
            prev_busy = busy;
            ad_in = 8'hEE;
            if (!cs_n && !ad_sel) begin
                if (!in_trans) begin
                    in_trans = 1'b1;
                    adr_cyc  = 0;
                    dat_cyc  = 0;
                    cur_addr = ad_out;
                end
                adr_cyc++;
                if (wr_n !== 1'b0 || rd_n !== 1'b1 || ad_oe !== 1'b1 || ad_out !== cur_addr) proto_err++;
            end else if (!cs_n && ad_sel) begin
                dat_cyc++;
                if (!wr_n) begin
                    cur_rw   = 1'b0;
                    cur_data = ad_out;
                    if (ad_oe !== 1'b1 || rd_n !== 1'b1) proto_err++;
                end else if (!rd_n) begin
                    cur_rw   = 1'b1;
                    ad_in    = rtc_mem[cur_addr];
                    cur_data = ad_in;
                    if (ad_oe !== 1'b0) proto_err++;
                end
            end else if (in_trans && dat_cyc == 0) begin
                if (!rd_n || !wr_n || !ad_sel || ad_oe !== 1'b1 || ad_out !== cur_addr) proto_err++;
            end else if (in_trans) begin
                in_trans = 1'b0;
                trans_done++;
                if (ad_oe !== 1'b0 || !rd_n || !wr_n || !ad_sel) proto_err++;
                if (exp_q.size() > 0) begin
                    checkOutput("bus_trans", {cur_rw, cur_addr, cur_data, 8'(adr_cyc), 8'(dat_cyc)},
                                exp_q.pop_front());
                end else begin
                    checkOutput("trans_unexpected", exp_q.size(), 1);
                end
            end

            if (data_valid) begin
                dv_count++;
                dv_cyc = cyc;
                checkOutput("dv_latency", cyc - busy_rise_cyc, 112);
                if (snap_q.size() > 0) begin
                    cur_snap = snap_q.pop_front();
                    checkOutput("snapshot", {sec, min, hour, day, mon, year}, cur_snap);
                end else begin
                    checkOutput("dv_unexpected", snap_q.size(), 1);
                end
            end else if ({sec, min, hour, day, mon, year} !== cur_snap) begin
                stable_err++;
            end
        end
    end

    initial begin
        int idle_bad;
        int base;
        reset     = 1'b1;
        init_done = 1'b0;
        hold      = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_bus", {cs_n, ad_sel, rd_n, wr_n}, 4'hF);
        checkOutput("rst_ad_oe", ad_oe, 0);
        checkOutput("rst_ad_out", ad_out, 8'h00);
        checkOutput("rst_snap", {sec, min, hour, day, mon, year}, 48'h0);
        checkOutput("rst_dv_busy", {data_valid, busy}, 2'b00);
        reset = 1'b0;

        idle_bad = 0;
        repeat (500) begin
            @(negedge clk);
            if (!cs_n || busy) idle_bad++;
        end
        checkOutput("no_init_idle", idle_bad, 0);

        applyStimulus(48'h45_30_12_07_03_24, 1'b1);
        init_done = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("busy_rise", busy, 1);
        checkOutput("first_adr", {cs_n, ad_sel, wr_n, ad_out}, {3'b000, 8'hF0});
        waitDv(1, 300, "wait_dv1");

        applyStimulus(48'h59_31_13_08_04_25, 1'b1);
        waitBusy(2, 400, "wait_burst2");
        checkOutput("refresh_gap", busy_rise_cyc - dv_cyc, 200);
        waitDv(2, 300, "wait_dv2");

        applyStimulus(48'h00_32_14_09_05_26, 1'b0);
        base = trans_done;
        waitBusy(3, 400, "wait_burst3");
        waitTrans(base + 3, 200, "wait_read2");
        repeat (8) @(negedge clk);
        hold = 1'b1;
        for (int i = 0; i < 300 && busy; i++) @(negedge clk);
        checkOutput("hold_busy_fall", busy, 0);
        checkOutput("hold_all_trans", trans_done - base, 7);
        checkOutput("hold_exp_empty", exp_q.size(), 0);
        repeat (300) @(negedge clk);
        checkOutput("hold_no_burst", busy_rises, 3);
        checkOutput("hold_no_dv", dv_count, 2);
        checkOutput("hold_keep", {sec, min, hour, day, mon, year}, 48'h59_31_13_08_04_25);
        applyStimulus(48'h01_33_15_10_06_27, 1'b1);
        hold = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("hold_restart", busy, 1);
        waitDv(3, 300, "wait_dv3");

        applyStimulus(48'h02_34_16_11_07_28, 1'b1);
        base = trans_done;
        waitTrans(base + 2, 500, "wait_read1");
        for (int i = 0; i < 40 && rd_n; i++) @(negedge clk);
        checkOutput("reach_read_dat", rd_n, 0);
        reset     = 1'b1;
        init_done = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("mid_rst_bus", {cs_n, rd_n, wr_n}, 3'b111);
        checkOutput("mid_rst_ad_oe", ad_oe, 0);
        checkOutput("mid_rst_snap", {sec, min, hour, day, mon, year}, 48'h0);
        checkOutput("mid_rst_busy_dv", {busy, data_valid}, 2'b00);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("post_rst_idle", {busy, cs_n}, 2'b01);
        checkOutput("snap_stable", stable_err, 0);
        checkOutput("bus_protocol", proto_err, 0);
        checkOutput("total_dv", dv_count, 3);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
